ifu_ibuf: RTL and testbench

Instruction fetch buffer that sits directly downstream of the instruction-fetch unit. It accepts line fetch requests (line address plus start-word select) and pairs them in order with 128-bit memory responses. It then issues one 32-bit instruction per cycle with its PC to the decode stage. It generates the fetch-ready back-pressure to the fetch unit and discards in-flight lines on a jump flush.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_ibuf_chk.sv | 32 +++
 rtl/ifu_ibuf_mem.sv | 62 ++++++
 rtl/ifu_ibuf.sv | 133 +++++++++++++
 tb/tb_ifu_ibuf.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared widths, line-entry layout and word-extract helper for the instruction fetch buffer.
package ifu_pkg;
   localparam int PC_WIDTH       = 30;
   localparam int LINE_WIDTH     = 128;
   localparam int INSTR_WIDTH    = 32;
   localparam int WORDS_PER_LINE = 4;
   localparam int LA_WIDTH       = PC_WIDTH - 2;

   typedef struct packed {
      logic                  valid;
      logic                  filled;
      logic [LA_WIDTH-1:0]   addr;
      logic [1:0]            sel;
      logic [LINE_WIDTH-1:0] data;
   } ibufEntry_t;

   function automatic logic [INSTR_WIDTH-1:0] lineWord(input logic [LINE_WIDTH-1:0] line,
                                                       input logic [1:0]            idx);
      return line[32'(idx) * INSTR_WIDTH +: INSTR_WIDTH];
   endfunction
endpackage

// File: rtl/ifu_ibuf_chk.sv
// Protocol checks for the fetch buffer: ready discipline, orphan responses, overflow.
module ifu_ibuf_chk #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input logic             i_Clk,
   input logic             i_RstN,
   input logic             i_FetchV,
   input logic             i_FetchR,
   input logic             i_MemRspV,
   input logic             i_Flush,
   input logic [CNT_W-1:0] i_OccCnt,
   input logic [CNT_W-1:0] i_PendCnt,
   input logic [CNT_W-1:0] i_DropCnt
);
   logic fetchRPrev_r;

   // Ready offered in the previous cycle.
   always_ff @(posedge i_Clk or negedge i_RstN) begin
      if (!i_RstN) fetchRPrev_r <= 1'b1;
      else         fetchRPrev_r <= i_FetchR;
   end

   a_fetchAfterReady: assert property (@(posedge i_Clk) disable iff (!i_RstN)
      i_FetchV |-> fetchRPrev_r);
   a_rspOutstanding: assert property (@(posedge i_Clk) disable iff (!i_RstN)
      i_MemRspV |-> (i_PendCnt != '0 || i_DropCnt != '0));
   a_noAllocWhenFull: assert property (@(posedge i_Clk) disable iff (!i_RstN)
      (i_FetchV && !i_Flush) |-> (i_OccCnt != CNT_W'(DEPTH)));
   a_dropBound: assert property (@(posedge i_Clk) disable iff (!i_RstN)
      i_DropCnt <= CNT_W'(DEPTH));
endmodule

// File: rtl/ifu_ibuf_mem.sv
// Line-entry storage: alloc and fill write ports, head read port, synchronous clear.
module ifu_ibuf_mem
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                  i_Clk,
   input  logic                  i_RstN,
   input  logic                  i_Clear,
   input  logic                  i_AllocEn,
   input  logic [PTR_W-1:0]      i_AllocIdx,
   input  logic [LA_WIDTH-1:0]   i_AllocAddr,
   input  logic [1:0]            i_AllocSel,
   input  logic                  i_FillEn,
   input  logic [PTR_W-1:0]      i_FillIdx,
   input  logic [LINE_WIDTH-1:0] i_FillData,
   input  logic                  i_PopEn,
   input  logic [PTR_W-1:0]      i_HeadIdx,
   output logic                  o_HeadValid,
   output logic                  o_HeadFilled,
   output logic [LA_WIDTH-1:0]   o_HeadAddr,
   output logic [LINE_WIDTH-1:0] o_HeadData,
   output logic [1:0]            o_NextSel
);
   ibufEntry_t       entries_r [DEPTH];
   logic [PTR_W-1:0] nextIdx_s;

   // Entry array update: clear on flush, otherwise pop, alloc and fill writes.
   always_ff @(posedge i_Clk or negedge i_RstN) begin
      if (!i_RstN) begin
         for (int i = 0; i < DEPTH; i++) entries_r[i] <= '0;
      end else if (i_Clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i].valid  <= 1'b0;
            entries_r[i].filled <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_PopEn && i_HeadIdx == PTR_W'(i)) entries_r[i].valid <= 1'b0;
            if (i_AllocEn && i_AllocIdx == PTR_W'(i)) begin
               entries_r[i].valid  <= 1'b1;
               entries_r[i].filled <= 1'b0;
               entries_r[i].addr   <= i_AllocAddr;
               entries_r[i].sel    <= i_AllocSel;
            end
            if (i_FillEn && i_FillIdx == PTR_W'(i)) begin
               entries_r[i].filled <= 1'b1;
               entries_r[i].data   <= i_FillData;
            end
         end
      end
   end

   // The entry behind the head supplies the start word when the head pops.
   assign nextIdx_s    = i_HeadIdx + PTR_W'(1);
   assign o_HeadValid  = entries_r[i_HeadIdx].valid;
   assign o_HeadFilled = entries_r[i_HeadIdx].filled;
   assign o_HeadAddr   = entries_r[i_HeadIdx].addr;
   assign o_HeadData   = entries_r[i_HeadIdx].data;
   assign o_NextSel    = entries_r[nextIdx_s].sel;
endmodule

// File: rtl/ifu_ibuf.sv
// Instruction fetch buffer: pairs line requests with in-order memory responses and
// issues one instruction per cycle to decode; flush discards everything in flight.
module ifu_ibuf
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_Clk,
   input  logic                   i_RstN,
   input  logic                   i_FetchV,
   input  logic [LA_WIDTH-1:0]    i_FetchA,
   input  logic [1:0]             i_InstrSel,
   output logic                   o_FetchR,
   input  logic                   i_MemRspV,
   input  logic [LINE_WIDTH-1:0]  i_MemRspD,
   input  logic                   i_Flush,
   output logic                   o_InstrV,
   output logic [INSTR_WIDTH-1:0] o_Instr,
   output logic [PC_WIDTH-1:0]    o_InstrPC,
   input  logic                   i_InstrR
);
   localparam int               PTR_W     = $clog2(DEPTH);
   localparam int               CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [1:0]       LAST_WORD = 2'(WORDS_PER_LINE - 1);

   logic [PTR_W-1:0]      allocPtr_r, fillPtr_r, headPtr_r;
   logic [CNT_W-1:0]      occCnt_r, pendCnt_r, dropCnt_r, flushDrop_s;
   logic [CNT_W:0]        reserved_s, flushSum_s;
   logic [1:0]            word_r, wordNext_s, nextSel_s;
   logic                  headValid_s, headFilled_s;
   logic [LA_WIDTH-1:0]   headAddr_s;
   logic [LINE_WIDTH-1:0] headData_s;
   logic                  alloc_s, fill_s, fire_s, pop_s, dropping_s, instrV_s;

   assign dropping_s = (dropCnt_r != '0);
   assign alloc_s    = i_FetchV && !i_Flush;
   assign fill_s     = i_MemRspV && !dropping_s && !i_Flush;
   assign instrV_s   = headValid_s && headFilled_s;
   assign fire_s     = instrV_s && i_InstrR;
   assign pop_s      = fire_s && (word_r == LAST_WORD) && !i_Flush;
   assign reserved_s = {1'b0, occCnt_r} + {1'b0, dropCnt_r} + (CNT_W+1)'(i_FetchV);
   assign o_FetchR   = (reserved_s < (CNT_W+1)'(DEPTH));

   ifu_ibuf_mem #(.DEPTH(DEPTH)) uMem (
      .i_Clk        (i_Clk),
      .i_RstN       (i_RstN),
      .i_Clear      (i_Flush),
      .i_AllocEn    (alloc_s),
      .i_AllocIdx   (allocPtr_r),
      .i_AllocAddr  (i_FetchA),
      .i_AllocSel   (i_InstrSel),
      .i_FillEn     (fill_s),
      .i_FillIdx    (fillPtr_r),
      .i_FillData   (i_MemRspD),
      .i_PopEn      (pop_s),
      .i_HeadIdx    (headPtr_r),
      .o_HeadValid  (headValid_s),
      .o_HeadFilled (headFilled_s),
      .o_HeadAddr   (headAddr_s),
      .o_HeadData   (headData_s),
      .o_NextSel    (nextSel_s)
   );

   // Drops after a flush: every response still owed, pending drops carried over.
   always_comb begin
      flushSum_s = {1'b0, dropCnt_r} + {1'b0, pendCnt_r} + (CNT_W+1)'(i_FetchV)
                 - (CNT_W+1)'(i_MemRspV);
      if (flushSum_s > (CNT_W+1)'(DEPTH)) flushDrop_s = DEPTH_C;
      else                                flushDrop_s = flushSum_s[CNT_W-1:0];
   end

   // Word cursor: start word of whichever line becomes head, else advance on handshake.
   always_comb begin
      wordNext_s = word_r;
      if (pop_s) begin
         if (occCnt_r > CNT_W'(1)) wordNext_s = nextSel_s;
         else if (alloc_s)         wordNext_s = i_InstrSel;
         else                      wordNext_s = 2'd0;
      end else if (fire_s) begin
         wordNext_s = word_r + 2'd1;
      end else if (alloc_s && occCnt_r == '0) begin
         wordNext_s = i_InstrSel;
      end else begin
         wordNext_s = word_r;
      end
   end

   // Pointers and counters; flush wins over every other event.
   always_ff @(posedge i_Clk or negedge i_RstN) begin
      if (!i_RstN) begin
         allocPtr_r <= '0;
         fillPtr_r  <= '0;
         headPtr_r  <= '0;
         occCnt_r   <= '0;
         pendCnt_r  <= '0;
         dropCnt_r  <= '0;
         word_r     <= 2'd0;
      end else if (i_Flush) begin
         allocPtr_r <= '0;
         fillPtr_r  <= '0;
         headPtr_r  <= '0;
         occCnt_r   <= '0;
         pendCnt_r  <= '0;
         dropCnt_r  <= flushDrop_s;
         word_r     <= 2'd0;
      end else begin
         if (alloc_s) allocPtr_r <= allocPtr_r + PTR_W'(1);
         if (fill_s)  fillPtr_r  <= fillPtr_r + PTR_W'(1);
         if (pop_s)   headPtr_r  <= headPtr_r + PTR_W'(1);
         if (i_MemRspV && dropping_s) dropCnt_r <= dropCnt_r - CNT_W'(1);
         occCnt_r  <= occCnt_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
         pendCnt_r <= pendCnt_r + CNT_W'(alloc_s) - CNT_W'(fill_s);
         word_r    <= wordNext_s;
      end
   end

   assign o_InstrV  = instrV_s;
   assign o_Instr   = instrV_s ? lineWord(headData_s, word_r) : '0;
   assign o_InstrPC = instrV_s ? {headAddr_s, word_r} : '0;

   ifu_ibuf_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) uChk (
      .i_Clk     (i_Clk),
      .i_RstN    (i_RstN),
      .i_FetchV  (i_FetchV),
      .i_FetchR  (o_FetchR),
      .i_MemRspV (i_MemRspV),
      .i_Flush   (i_Flush),
      .i_OccCnt  (occCnt_r),
      .i_PendCnt (pendCnt_r),
      .i_DropCnt (dropCnt_r)
   );
endmodule

// File: tb/tb_ifu_ibuf.sv
// Randomized bench for ifu_ibuf against a queue-of-lines reference model.
module tb_ifu_ibuf;
   import ifu_pkg::*;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rstN;
   logic                   fetchV, memRspV, flush, instrR;
   logic [LA_WIDTH-1:0]    fetchA;
   logic [1:0]             instrSel;
   logic [LINE_WIDTH-1:0]  memRspD;
   logic                   fetchR, instrV;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    instrPC;

   always #5 clk = ~clk;

   ifu_ibuf #(.DEPTH(DEPTH)) dut (
      .i_Clk(clk), .i_RstN(rstN), .i_FetchV(fetchV), .i_FetchA(fetchA),
      .i_InstrSel(instrSel), .o_FetchR(fetchR), .i_MemRspV(memRspV),
      .i_MemRspD(memRspD), .i_Flush(flush), .o_InstrV(instrV), .o_Instr(instr),
      .o_InstrPC(instrPC), .i_InstrR(instrR)
   );

   // Each buffered line remembers the next word it will hand to decode.
   typedef struct {
      logic [LA_WIDTH-1:0]   addr;
      logic [1:0]            word;
      logic                  filled;
      logic [LINE_WIDTH-1:0] data;
   } line_t;

   line_t                  lineQ[$];
   int                     deadCnt;
   logic                   lastReady;
   int                     testCnt, failCnt, allocCnt;
   logic                   obsV, obsR;
   logic [INSTR_WIDTH-1:0] obsInstr;
   logic [PC_WIDTH-1:0]    obsPC;
   logic [LINE_WIDTH-1:0]  lineA, lineB;

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      testCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unfilledCount();
      int n = 0;
      foreach (lineQ[i]) if (!lineQ[i].filled) n++;
      return n;
   endfunction

   function automatic logic [LINE_WIDTH-1:0] randLine();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fillFirst(input logic [LINE_WIDTH-1:0] d);
      for (int i = 0; i < lineQ.size(); i++) begin
         if (!lineQ[i].filled) begin
            line_t l = lineQ[i];
            l.filled = 1'b1;
            l.data   = d;
            lineQ[i] = l;
            return;
         end
      end
   endtask

   task automatic modelUpdate(input logic fv, input logic [LA_WIDTH-1:0] fa, input logic [1:0] fs,
                              input logic rv, input logic [LINE_WIDTH-1:0] rd, input logic fl,
                              input logic fire);
      line_t l;
      if (rv) begin
         if (deadCnt > 0) deadCnt--;
         else             fillFirst(rd);
      end
      if (fl) begin
         deadCnt += unfilledCount() + int'(fv);
         lineQ.delete();
         return;
      end
      if (fire) begin
         l = lineQ[0];
         if (l.word == 2'd3) void'(lineQ.pop_front());
         else begin
            l.word   = l.word + 2'd1;
            lineQ[0] = l;
         end
      end
      if (fv) begin
         l.addr = fa; l.word = fs; l.filled = 1'b0; l.data = '0;
         lineQ.push_back(l);
      end
   endtask

   task automatic stepCycle(input logic fv, input logic [LA_WIDTH-1:0] fa, input logic [1:0] fs,
                            input logic rv, input logic [LINE_WIDTH-1:0] rd, input logic fl,
                            input logic ir);
      logic                   expV, expR;
      logic [INSTR_WIDTH-1:0] expI;
      logic [PC_WIDTH-1:0]    expPC;
      logic [LINE_WIDTH-1:0]  sh;
      line_t                  h;
      @(negedge clk);
      fetchV = fv; fetchA = fa; instrSel = fs; memRspV = rv; memRspD = rd; flush = fl; instrR = ir;
      #1;
      expV = 1'b0; expI = '0; expPC = '0;
      if (lineQ.size() > 0 && lineQ[0].filled) begin
         h     = lineQ[0];
         expV  = 1'b1;
         sh    = h.data >> (32 * h.word);
         expI  = sh[31:0];
         expPC = {h.addr, h.word};
      end
      expR = (lineQ.size() + deadCnt + int'(fv)) < DEPTH;
      checkVal("instrV", instrV, expV);
      checkVal("instr", instr, expI);
      checkVal("instrPC", instrPC, expPC);
      checkVal("fetchR", fetchR, expR);
      obsV = instrV; obsR = fetchR; obsInstr = instr; obsPC = instrPC;
      lastReady = expR;
      @(posedge clk);
      modelUpdate(fv, fa, fs, rv, rd, fl, expV && ir);
   endtask

   task automatic idle(input logic ir);
      stepCycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, ir);
   endtask

   initial begin
      testCnt = 0; failCnt = 0; deadCnt = 0; lastReady = 1'b1; allocCnt = 0;
      rstN = 1'b0; fetchV = 1'b0; fetchA = '0; instrSel = 2'd0; memRspV = 1'b0;
      memRspD = '0; flush = 1'b0; instrR = 1'b0;
      #12;
      checkVal("rst_instrV", instrV, 1'b0);
      checkVal("rst_fetchR", fetchR, 1'b1);
      checkVal("rst_instr", instr, 32'h0);
      checkVal("rst_pc", instrPC, 30'h0);
      @(negedge clk); rstN = 1'b1;

      // Basic fetch of a full line
      stepCycle(1'b1, 28'h10, 2'd0, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b1, 128'h33333333_22222222_11111111_00000000, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         checkVal("basic_pc", obsPC, 30'h40 + k);
         checkVal("basic_instr", obsInstr, 32'h11111111 * k);
      end
      idle(1'b1);
      checkVal("basic_empty", obsV, 1'b0);

      // Start-word select skips words 0 and 1
      lineA = randLine();
      stepCycle(1'b1, 28'h20, 2'd2, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b1, lineA, 1'b0, 1'b1);
      idle(1'b1);
      checkVal("sel_pc2", obsPC, 30'h82);
      checkVal("sel_instr2", obsInstr, lineA[95:64]);
      idle(1'b1);
      checkVal("sel_pc3", obsPC, 30'h83);
      idle(1'b1);
      checkVal("sel_popped", obsV, 1'b0);

      // Back-pressure: allocate until ready drops while decode stalls
      obsR = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (!obsR) break;
         stepCycle(1'b1, 28'h100 + 28'(k), (k == 0) ? 2'd3 : 2'd0, 1'b0, '0, 1'b0, 1'b0);
         allocCnt++;
      end
      checkVal("bp_allocs", allocCnt, 4);
      for (int k = 0; k < 4; k++) stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b0);
      checkVal("bp_full", obsR, 1'b0);
      idle(1'b1);
      checkVal("bp_ready_at_pop", obsR, 1'b0);
      idle(1'b0);
      checkVal("bp_ready_after_pop", obsR, 1'b1);
      for (int k = 0; k < 14; k++) idle(1'b1);

      // Flush with three lines in flight
      for (int k = 0; k < 3; k++) stepCycle(1'b1, 28'h30 + 28'(k), 2'd0, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b1);
         checkVal("flush_dropped", obsV, 1'b0);
      end
      idle(1'b1);
      checkVal("flush_still_empty", obsV, 1'b0);
      stepCycle(1'b1, 28'h50, 2'd1, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b1);
      idle(1'b1);
      checkVal("flush_refetch_pc", obsPC, 30'h141);
      for (int k = 0; k < 4; k++) idle(1'b1);

      // Flush, response and fetch in the same cycle
      stepCycle(1'b1, 28'h60, 2'd0, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b1, 28'h61, 2'd0, 1'b1, randLine(), 1'b1, 1'b1);
      idle(1'b1);
      checkVal("coll_empty", obsV, 1'b0);
      stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b1);
      checkVal("coll_drop_v", obsV, 1'b0);
      lineB = randLine();
      stepCycle(1'b1, 28'h70, 2'd0, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b1, lineB, 1'b0, 1'b1);
      idle(1'b1);
      checkVal("coll_next_v", obsV, 1'b1);
      checkVal("coll_next_pc", obsPC, 30'h1C0);
      checkVal("coll_next_instr", obsInstr, lineB[31:0]);
      for (int k = 0; k < 4; k++) idle(1'b1);

      // Asynchronous reset with two lines buffered
      stepCycle(1'b1, 28'h80, 2'd0, 1'b0, '0, 1'b0, 1'b0);
      stepCycle(1'b1, 28'h81, 2'd0, 1'b0, '0, 1'b0, 1'b0);
      stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b0);
      stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b0);
      idle(1'b0);
      checkVal("arst_before", obsV, 1'b1);
      @(negedge clk); #2;
      rstN = 1'b0;
      #1;
      checkVal("arst_instrV", instrV, 1'b0);
      checkVal("arst_fetchR", fetchR, 1'b1);
      lineQ.delete(); deadCnt = 0; lastReady = 1'b1;
      @(negedge clk); rstN = 1'b1;
      stepCycle(1'b1, 28'h90, 2'd0, 1'b0, '0, 1'b0, 1'b1);
      stepCycle(1'b0, '0, 2'd0, 1'b1, randLine(), 1'b0, 1'b1);
      idle(1'b1);
      checkVal("arst_fresh_pc", obsPC, 30'h240);

      // Random traffic under the fetch and memory protocol rules
      for (int n = 0; n < 3000; n++) begin
         logic fv, rv, fl, ir;
         fv = lastReady && ($urandom_range(0, 1) == 1);
         rv = ((deadCnt + unfilledCount()) > 0) && ($urandom_range(0, 9) < 4);
         fl = ($urandom_range(0, 31) == 0);
         ir = ($urandom_range(0, 9) < 7);
         stepCycle(fv, 28'($urandom), 2'($urandom), rv, randLine(), fl, ir);
      end

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end
endmodule
